// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the request, response and memory-pin signals of mem_access_ctrl.
//   The controller connects through the slave modport. The master modport is the
//   opposite side: the datapath issuing requests plus the memory returning mem_q.
// Signals
//   req_valid/req_ready/req_wr/req_adrs/req_wdata/req_len : request handshake
//   mem_we_n/mem_adrs/mem_d_in/mem_q                       : single-port memory pins
//   rsp_valid/rsp_data/rsp_last                            : read response strobe
//   wr_done/verify_err                                     : write status
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int WORD_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_adrs;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic [ADDR_WIDTH-1:0] req_len;
  logic                  mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_adrs;
  logic [WORD_WIDTH-1:0] mem_d_in;
  logic [WORD_WIDTH-1:0] mem_q;
  logic                  rsp_valid;
  logic [WORD_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  wr_done;
  logic                  verify_err;

  modport master (
    output req_valid, req_wr, req_adrs, req_wdata, req_len, mem_q,
    input  req_ready, mem_we_n, mem_adrs, mem_d_in,
           rsp_valid, rsp_data, rsp_last, wr_done, verify_err
  );

  modport slave (
    input  req_valid, req_wr, req_adrs, req_wdata, req_len, mem_q,
    output req_ready, mem_we_n, mem_adrs, mem_d_in,
           rsp_valid, rsp_data, rsp_last, wr_done, verify_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Requester-side controller for a single-port synchronous memory (write on the
//   clock edge while mem_we_n is low, read data registered RD_LATENCY edges after
//   the address). Accepts valid/ready requests, performs single-beat writes and
//   auto-incrementing burst reads, and returns read data on a one-cycle strobe.
// Ports
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : mem_access_ctrl_if.slave (request, memory pins, response, status)
// Build option
//   WRITE_VERIFY_EN : when defined, every write is read back and compared; a
//                     mismatch sets the sticky verify_err flag and wr_done is
//                     delayed until after the compare. When undefined, verify_err
//                     is tied low.
//
// state        | meaning
// IDLE         | req_ready high, waiting for a request
// WRITE        | mem_we_n low, memory commits the word on the closing edge
// RD_ISSUE     | read address on the memory pins, memory samples it
// RD_WAIT      | counting RD_LATENCY edges, capture mem_q on terminal count
// VERIFY_ISSUE | re-read of the address just written
// VERIFY_WAIT  | counting RD_LATENCY edges, compare mem_q with written data
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int WORD_DEPTH = 4,
  parameter int WORD_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3
`ifdef WRITE_VERIFY_EN
    ,
    VERIFY_ISSUE = 3'd4,
    VERIFY_WAIT  = 3'd5
`endif
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] beats_left;
  logic [CNT_W-1:0]      wait_cnt;
  logic [ADDR_WIDTH-1:0] next_adrs;

  // Explicit wrap so a WORD_DEPTH smaller than 2**ADDR_WIDTH still wraps correctly.
  assign next_adrs = (bus.mem_adrs == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0
                                                                   : bus.mem_adrs + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.mem_we_n  <= 1'b1;
      bus.mem_adrs  <= '0;
      bus.mem_d_in  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_last  <= 1'b0;
      bus.wr_done   <= 1'b0;
      beats_left    <= '0;
      wait_cnt      <= '0;
`ifdef WRITE_VERIFY_EN
      bus.verify_err <= 1'b0;
`endif
    end else begin
      // Strobes last exactly one cycle.
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.wr_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            bus.mem_adrs  <= bus.req_adrs;
            if (bus.req_wr) begin
              bus.mem_we_n <= 1'b0;
              bus.mem_d_in <= bus.req_wdata;
              state        <= WRITE;
            end else begin
              beats_left <= bus.req_len;
              state      <= RD_ISSUE;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        WRITE: begin
          bus.mem_we_n <= 1'b1;
`ifdef WRITE_VERIFY_EN
          state <= VERIFY_ISSUE;
`else
          bus.wr_done   <= 1'b1;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
`endif
        end

        RD_ISSUE: begin
          wait_cnt <= CNT_W'(RD_LATENCY - 1);
          state    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (wait_cnt == '0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.mem_q;
            if (beats_left == '0) begin
              bus.rsp_last  <= 1'b1;
              bus.req_ready <= 1'b1;
              state         <= IDLE;
            end else begin
              beats_left   <= beats_left - 1'b1;
              bus.mem_adrs <= next_adrs;
              state        <= RD_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

`ifdef WRITE_VERIFY_EN
        VERIFY_ISSUE: begin
          wait_cnt <= CNT_W'(RD_LATENCY - 1);
          state    <= VERIFY_WAIT;
        end

        VERIFY_WAIT: begin
          if (wait_cnt == '0) begin
            // mem_d_in still holds the word that was written.
            if (bus.mem_q != bus.mem_d_in) begin
              bus.verify_err <= 1'b1;
            end
            bus.wr_done   <= 1'b1;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
`endif

        default: begin
          bus.mem_we_n  <= 1'b1;
          bus.req_ready <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifndef WRITE_VERIFY_EN
  assign bus.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. Models the single-port memory (one-edge
//   registered read) including a stuck bit0 on writes of 0x5A to address 1.
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

`ifdef WRITE_VERIFY_EN
  localparam int   WR_CYC  = 4;
  localparam logic EXP_ERR = 1'b1;
`else
  localparam int   WR_CYC  = 2;
  localparam logic EXP_ERR = 1'b0;
`endif

  mem_access_ctrl_if #(.ADDR_WIDTH(2), .WORD_WIDTH(8)) bus ();

  mem_access_ctrl #(
    .ADDR_WIDTH(2),
    .WORD_DEPTH(4),
    .WORD_WIDTH(8),
    .RD_LATENCY(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [4];

  always @(posedge clk) begin
    bus.mem_q <= mem[bus.mem_adrs];
    if (!bus.mem_we_n) begin
      if (bus.mem_adrs == 2'd1 && bus.mem_d_in == 8'h5A)
        mem[bus.mem_adrs] <= bus.mem_d_in ^ 8'h01;
      else
        mem[bus.mem_adrs] <= bus.mem_d_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.rsp_valid && bus.wr_done) begin
        errors++;
        $display("FAIL strobe_excl: rsp_valid=%0b wr_done=%0b, required not both", bus.rsp_valid, bus.wr_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns 1 time unit after its accept edge E0.
  task automatic send(input logic wr, input logic [1:0] adrs, input logic [7:0] wdata,
                      input logic [1:0] len);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_adrs  = adrs;
    bus.req_wdata = wdata;
    bus.req_len   = len;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b, required 1 within 20 cycles", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wr_done();
    int n = 0;
    while (!bus.wr_done && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL wr_done_timeout: wr_done=%0b, required 1 within 20 cycles", bus.wr_done);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", bus.req_ready); end
    checks++; if (bus.mem_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %0b want 1", bus.mem_we_n); end
    checks++; if (bus.mem_adrs !== 2'd0) begin errors++; $display("FAIL rst_adrs: got %0d want 0", bus.mem_adrs); end
    checks++; if (bus.mem_d_in !== 8'h00) begin errors++; $display("FAIL rst_d_in: got %h want 00", bus.mem_d_in); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0 || bus.rsp_data !== 8'h00) begin
      errors++; $display("FAIL rst_rsp: valid=%0b last=%0b data=%h want 0 0 00", bus.rsp_valid, bus.rsp_last, bus.rsp_data);
    end
    checks++; if (bus.wr_done !== 1'b0 || bus.verify_err !== 1'b0) begin
      errors++; $display("FAIL rst_status: wr_done=%0b verify_err=%0b want 0 0", bus.wr_done, bus.verify_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hold: got %0b want 0", bus.req_ready); end
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %0b want 1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    send(1'b1, 2'd2, 8'hA5, 2'd0);
    checks++; if (bus.mem_we_n !== 1'b0 || bus.mem_adrs !== 2'd2 || bus.mem_d_in !== 8'hA5) begin
      errors++; $display("FAIL wr_pins: we_n=%0b adrs=%0d d=%h want 0 2 a5", bus.mem_we_n, bus.mem_adrs, bus.mem_d_in);
    end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wr_busy: ready=%0b want 0", bus.req_ready); end
    for (int k = 1; k < WR_CYC; k++) begin
      tick();
      checks++; if (bus.mem_we_n !== 1'b1) begin errors++; $display("FAIL wr_we_release: we_n=%0b want 1 at +%0d", bus.mem_we_n, k); end
      checks++; if (bus.wr_done !== (k == WR_CYC - 1)) begin
        errors++; $display("FAIL wr_done_time: wr_done=%0b want %0b at +%0d", bus.wr_done, (k == WR_CYC - 1), k);
      end
    end
    tick();
    checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %0b want 0", bus.wr_done); end
    send(1'b0, 2'd2, 8'h00, 2'd0);
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early: rsp_valid=%0b want 0", bus.rsp_valid); end
    checks++; if (bus.mem_we_n !== 1'b1) begin errors++; $display("FAIL rd_we_n: got %0b want 1", bus.mem_we_n); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hA5 || bus.rsp_last !== 1'b1) begin
      errors++; $display("FAIL rd_single: valid=%0b data=%h last=%0b want 1 a5 1", bus.rsp_valid, bus.rsp_data, bus.rsp_last);
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse: rsp_valid=%0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h33; exp_data[1] = 8'h44; exp_data[2] = 8'h11; exp_data[3] = 8'h22;
    send(1'b1, 2'd0, 8'h11, 2'd0); wait_wr_done();
    send(1'b1, 2'd1, 8'h22, 2'd0); wait_wr_done();
    send(1'b1, 2'd2, 8'h33, 2'd0); wait_wr_done();
    send(1'b1, 2'd3, 8'h44, 2'd0); wait_wr_done();
    send(1'b0, 2'd2, 8'h00, 2'd3);
    // Second request held pending for the whole burst.
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_adrs  = 2'd1;
    bus.req_len   = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (bus.req_ready !== (k == 8)) begin
        errors++; $display("FAIL burst_ready: ready=%0b want %0b at +%0d", bus.req_ready, (k == 8), k);
      end
      checks++; if (bus.rsp_valid !== (k % 2 == 0)) begin
        errors++; $display("FAIL burst_valid: rsp_valid=%0b want %0b at +%0d", bus.rsp_valid, (k % 2 == 0), k);
      end
      checks++; if (bus.mem_we_n !== 1'b1) begin errors++; $display("FAIL burst_we_n: got %0b want 1 at +%0d", bus.mem_we_n, k); end
      if (k % 2 == 0) begin
        checks++; if (bus.rsp_data !== exp_data[k/2-1] || bus.rsp_last !== (k == 8)) begin
          errors++; $display("FAIL burst_beat: data=%h last=%0b want %h %0b at +%0d", bus.rsp_data, bus.rsp_last, exp_data[k/2-1], (k == 8), k);
        end
      end
    end
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h22 || bus.rsp_last !== 1'b1) begin
      errors++; $display("FAIL b2b_read: valid=%0b data=%h last=%0b want 1 22 1", bus.rsp_valid, bus.rsp_data, bus.rsp_last);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    send(1'b0, 2'd0, 8'h00, 2'd3);
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h11) begin
      errors++; $display("FAIL abort_beat0: valid=%0b data=%h want 1 11", bus.rsp_valid, bus.rsp_data);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.mem_adrs !== 2'd0 || bus.mem_we_n !== 1'b1) begin
      errors++; $display("FAIL abort_async: valid=%0b ready=%0b adrs=%0d we_n=%0b want 0 0 0 1",
                         bus.rsp_valid, bus.req_ready, bus.mem_adrs, bus.mem_we_n);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL abort_hold: valid=%0b ready=%0b want 0 0", bus.rsp_valid, bus.req_ready);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL abort_release: valid=%0b ready=%0b want 0 1", bus.rsp_valid, bus.req_ready);
      end
    end
    // Reset during the write cycle must cancel the write.
    send(1'b1, 2'd3, 8'h77, 2'd0);
    checks++; if (bus.mem_we_n !== 1'b0) begin errors++; $display("FAIL abort_wr_pre: we_n=%0b want 0", bus.mem_we_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we_n !== 1'b1) begin errors++; $display("FAIL abort_wr_we_n: we_n=%0b want 1", bus.mem_we_n); end
    tick();
    rst_n = 1'b1;
    tick();
    send(1'b0, 2'd3, 8'h00, 2'd0);
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h44) begin
      errors++; $display("FAIL abort_no_write: valid=%0b data=%h want 1 44", bus.rsp_valid, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send(1'b1, 2'd0, 8'h10, 2'd0);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_adrs  = 2'd3;
    bus.req_wdata = 8'h30;
    for (int k = 1; k < WR_CYC; k++) tick();
    checks++; if (bus.wr_done !== 1'b1 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: wr_done=%0b ready=%0b want 1 1", bus.wr_done, bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_we_n !== 1'b0 || bus.mem_adrs !== 2'd3 || bus.mem_d_in !== 8'h30) begin
      errors++; $display("FAIL b2b_second: we_n=%0b adrs=%0d d=%h want 0 3 30", bus.mem_we_n, bus.mem_adrs, bus.mem_d_in);
    end
    wait_wr_done();
    tick();
    send(1'b0, 2'd3, 8'h00, 2'd1);
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h30 || bus.rsp_last !== 1'b0) begin
      errors++; $display("FAIL wrap_beat0: valid=%0b data=%h last=%0b want 1 30 0", bus.rsp_valid, bus.rsp_data, bus.rsp_last);
    end
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h10 || bus.rsp_last !== 1'b1) begin
      errors++; $display("FAIL wrap_beat1: valid=%0b data=%h last=%0b want 1 10 1", bus.rsp_valid, bus.rsp_data, bus.rsp_last);
    end
    tick();
  endtask

  task automatic test_verify();
    send(1'b1, 2'd1, 8'h5A, 2'd0);
    for (int k = 1; k < WR_CYC; k++) tick();
    checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL verify_done_time: wr_done=%0b want 1", bus.wr_done); end
    checks++; if (bus.verify_err !== EXP_ERR) begin
      errors++; $display("FAIL verify_err_set: verify_err=%0b want %0b", bus.verify_err, EXP_ERR);
    end
    tick(); tick();
    send(1'b1, 2'd0, 8'h3C, 2'd0);
    for (int k = 1; k < WR_CYC; k++) tick();
    checks++; if (bus.wr_done !== 1'b1 || bus.verify_err !== EXP_ERR) begin
      errors++; $display("FAIL verify_sticky: wr_done=%0b verify_err=%0b want 1 %0b", bus.wr_done, bus.verify_err, EXP_ERR);
    end
    tick(); tick();
    checks++; if (bus.verify_err !== EXP_ERR) begin
      errors++; $display("FAIL verify_sticky_late: verify_err=%0b want %0b", bus.verify_err, EXP_ERR);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_adrs  = 2'd0;
    bus.req_wdata = 8'h00;
    bus.req_len   = 2'd0;
    test_reset();
    test_write_read();
    test_burst();
    test_reset_abort();
    test_back_to_back();
    test_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
